// File: rtl/alu_operand_b_stage_if.sv
// rtl/alu_operand_b_stage_if.sv - operand-B stage input/output handshake bundle
interface alu_operand_b_stage_if #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 16
);
   logic [2:0]       sel;
   logic [WIDTH-1:0] reg_b;
   logic [IMM_W-1:0] imm;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   // Producer of instructions and consumer of operands
   modport master (
      output sel, reg_b, imm, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // The operand-B stage itself
   modport slave (
      input  sel, reg_b, imm, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/alu_operand_b_stage.sv
// rtl/alu_operand_b_stage.sv - ALU operand-B select/extend stage with skid buffer (optional OPB_FWD_EN)
module alu_operand_b_stage #(
   parameter int WIDTH     = 32,
   parameter int IMM_W     = 16,
   parameter int CONST_VAL = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_operand_b_stage_if.slave bus,
   input  logic                 err_clr,
   output logic                 err_illegal
`ifdef OPB_FWD_EN
   ,
   input  logic                 fwd_valid,
   input  logic [WIDTH-1:0]     fwd_data
`endif
);

   localparam logic [WIDTH-1:0] CONST_OP = WIDTH'(CONST_VAL);

   logic [WIDTH-1:0] sext;
   logic [WIDTH-1:0] zext;
   logic [WIDTH-1:0] regb_src;
   logic [WIDTH-1:0] operand;
   logic             illegal;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             skid_valid_q;
   logic [WIDTH-1:0] skid_data_q;

   logic             accept;
   logic             consume;

   // in_ready comes straight from the skid flag so out_ready never reaches it combinationally
   assign bus.in_ready  = ~skid_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   assign accept  = bus.in_valid & ~skid_valid_q;
   assign consume = out_valid_q & bus.out_ready;

`ifdef OPB_FWD_EN
   assign regb_src = fwd_valid ? fwd_data : bus.reg_b;
`else
   assign regb_src = bus.reg_b;
`endif

   // Operand select and immediate extension; illegal selects yield zero
   always_comb begin
      sext    = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
      zext    = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
      operand = '0;
      illegal = 1'b0;
      case (bus.sel)
         3'd0:    operand = regb_src;
         3'd1:    operand = CONST_OP;
         3'd2:    operand = sext;
         3'd3:    operand = zext;
         3'd4:    operand = sext << 2;
         3'd5:    operand = zext << 16;
         default: illegal = 1'b1;
      endcase
   end

   // Output register plus skid register; skid only fills when output is held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else if (!out_valid_q) begin
         if (accept) begin
            out_data_q  <= operand;
            out_valid_q <= 1'b1;
         end
      end else if (consume) begin
         if (skid_valid_q) begin
            out_data_q   <= skid_data_q;
            skid_valid_q <= 1'b0;
         end else if (accept) begin
            out_data_q <= operand;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_data_q  <= operand;
         skid_valid_q <= 1'b1;
      end
   end

   // Sticky illegal-select flag; a new illegal accept beats a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_illegal <= 1'b0;
      end else if (accept && illegal) begin
         err_illegal <= 1'b1;
      end else if (err_clr) begin
         err_illegal <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// tb/tb_alu_operand_b_stage.sv - directed scoreboard bench for alu_operand_b_stage
module tb_alu_operand_b_stage;

   logic clk;
   logic reset;
   logic err_clr;
   logic err_illegal;
`ifdef OPB_FWD_EN
   logic        fwd_valid;
   logic [31:0] fwd_data;
`endif

   alu_operand_b_stage_if #(.WIDTH(32), .IMM_W(16)) bus ();

   alu_operand_b_stage #(.WIDTH(32), .IMM_W(16), .CONST_VAL(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .err_clr     (err_clr),
      .err_illegal (err_illegal)
`ifdef OPB_FWD_EN
      ,
      .fwd_valid   (fwd_valid),
      .fwd_data    (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_next;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, pop/compare on consume, push on accept
   task automatic cyc();
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_underflow: observed output with %0d queued, expected at least 1", sb.size());
         end
         if (sb.size() > 0) check("sb_data", bus.out_data, sb.pop_front());
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(exp_next);
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [2:0] s, input logic [31:0] rb, input logic [15:0] im,
                      input logic [31:0] exp);
      bus.sel      = s;
      bus.reg_b    = rb;
      bus.imm      = im;
      bus.in_valid = 1'b1;
      exp_next     = exp;
      cyc();
   endtask

   initial begin
      reset         = 1'b0;
      err_clr       = 1'b0;
      bus.sel       = '0;
      bus.reg_b     = '0;
      bus.imm       = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      exp_next      = '0;
`ifdef OPB_FWD_EN
      fwd_valid     = 1'b0;
      fwd_data      = '0;
`endif

      #3;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_err", 32'(err_illegal), 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // constant operand, latency one
      bus.out_ready = 1'b1;
      put(3'd1, 32'h0, 16'h0, 32'h0000_0004);
      bus.in_valid = 1'b0;
      check("const_out_valid", 32'(bus.out_valid), 32'd1);
      cyc();
      check("const_drained", 32'(bus.out_valid), 32'd0);

      // back-to-back extensions
      put(3'd2, 32'h0, 16'h8001, 32'hFFFF_8001);
      put(3'd3, 32'h0, 16'h8001, 32'h0000_8001);
      check("b2b_valid_1", 32'(bus.out_valid), 32'd1);
      put(3'd4, 32'h0, 16'hFFFF, 32'hFFFF_FFFC);
      bus.in_valid = 1'b0;
      check("b2b_valid_2", 32'(bus.out_valid), 32'd1);
      check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();
      check("b2b_drained", 32'(bus.out_valid), 32'd0);

      // stall fills skid, then drains in order
      bus.out_ready = 1'b0;
      put(3'd5, 32'h0, 16'h1234, 32'h1234_0000);
      check("stall_in_ready_1", 32'(bus.in_ready), 32'd1);
      put(3'd0, 32'hDEAD_BEEF, 16'h0, 32'hDEAD_BEEF);
      bus.in_valid = 1'b0;
      check("stall_in_ready_0", 32'(bus.in_ready), 32'd0);
      check("stall_out_hold", bus.out_data, 32'h1234_0000);
      bus.out_ready = 1'b1;
      cyc();
      check("skid_in_ready_back", 32'(bus.in_ready), 32'd1);
      check("skid_out_valid", 32'(bus.out_valid), 32'd1);
      cyc();
      check("skid_drained", 32'(bus.out_valid), 32'd0);

      // illegal select and sticky error
      put(3'd7, 32'h1, 16'h1, 32'h0);
      bus.in_valid = 1'b0;
      check("illegal_set", 32'(err_illegal), 32'd1);
      cyc();
      err_clr = 1'b1;
      put(3'd6, 32'h1, 16'h1, 32'h0);
      bus.in_valid = 1'b0;
      check("illegal_set_wins", 32'(err_illegal), 32'd1);
      cyc();
      check("clr_same_as_drain", 32'(err_illegal), 32'd0);
      err_clr = 1'b0;

      // illegal select offered while in_ready low has no effect
      bus.out_ready = 1'b0;
      put(3'd0, 32'hAAAA_5555, 16'h0, 32'hAAAA_5555);
      put(3'd0, 32'h1111_1111, 16'h0, 32'h1111_1111);
      put(3'd7, 32'h0, 16'h0, 32'h0);
      bus.in_valid = 1'b0;
      check("blocked_no_err", 32'(err_illegal), 32'd0);
      check("blocked_in_ready", 32'(bus.in_ready), 32'd0);
      check("blocked_out_hold", bus.out_data, 32'hAAAA_5555);

      // asynchronous reset with both registers full
      #2;
      reset = 1'b0;
      #1;
      check("async_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_in_ready", 32'(bus.in_ready), 32'd1);
      check("async_out_data", bus.out_data, 32'd0);
      sb.delete();
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // first acceptance after reset behaves as from empty
      bus.out_ready = 1'b1;
      put(3'd3, 32'h0, 16'h00FF, 32'h0000_00FF);
      bus.in_valid = 1'b0;
      check("post_rst_valid", 32'(bus.out_valid), 32'd1);
      cyc();

      // forwarding (only with OPB_FWD_EN)
`ifdef OPB_FWD_EN
      fwd_valid = 1'b1;
      fwd_data  = 32'h0000_0055;
      put(3'd0, 32'h0000_0001, 16'h0, 32'h0000_0055);
      put(3'd2, 32'h0000_0001, 16'h0005, 32'h0000_0005);
      fwd_valid = 1'b0;
`else
      put(3'd0, 32'h0000_0001, 16'h0, 32'h0000_0001);
      put(3'd2, 32'h0000_0001, 16'h0005, 32'h0000_0005);
`endif
      bus.in_valid = 1'b0;
      cyc();
      cyc();
      check("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
